seq_gen: RTL and testbench

//  Serial bit-pattern transmitter: accepts a parallel pattern word via valid/ready,

---
 rtl/seq_gen_pkg.sv | 14 +
 rtl/seq_gen_bitsel.sv | 56 +++++
 rtl/seq_gen.sv | 124 ++++++++++++
 tb/tb_seq_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generate/detect blocks.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StGap   = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefaultW   = 8;
  localparam int unsigned DefaultGap = 2;

endpackage

// File: rtl/seq_gen_bitsel.sv
// Holds the latched pattern and the bit index; presents the bit that will be on dout next cycle.
module seq_gen_bitsel
  import seq_gen_pkg::*;
#(
  parameter int unsigned W = DefaultW,
  localparam int unsigned LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic [LW-1:0] load_len,
  input  logic          reload,
  input  logic          step,
  output logic          bit_next,
  output logic          last
);

  localparam int unsigned IW = $clog2(W);

  logic [W-1:0]  pat_q, pat_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    idx_d = idx_q;
    if (load) begin
      pat_d = load_data;
      len_d = load_len;
      idx_d = (load_len == '0) ? '0 : load_len - LW'(1);
    end else if (reload) begin
      idx_d = len_q - LW'(1);
    end else if (step) begin
      idx_d = idx_q - LW'(1);
    end
  end

  // Index is clamped below W, so the narrower slice never drops a set bit.
  assign bit_next = pat_d[idx_d[IW-1:0]];
  assign last     = (idx_q == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= '0;
      len_q <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: latches a word via valid/ready and shifts it out MSB-first,
// optionally repeating it with idle gaps.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned W          = DefaultW,
  parameter int unsigned GAP        = DefaultGap,
  parameter logic        IDLE_LEVEL = 1'b0,
  localparam int unsigned LW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [LW-1:0] in_len,
  input  logic [3:0]    in_rep,
  output logic          dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          done
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e        state_q, state_d;
  logic [3:0]    rep_q, rep_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [LW-1:0] len_c;
  logic          xfer, load, reload, step, bit_next, last;
  logic          in_ready_d, dout_d, dout_valid_d, busy_d, done_d;

  assign xfer  = in_valid & in_ready;
  assign len_c = (in_len > LW'(W)) ? LW'(W) : in_len;

  seq_gen_bitsel #(
    .W (W)
  ) u_bitsel (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (in_data),
    .load_len  (len_c),
    .reload    (reload),
    .step      (step),
    .bit_next  (bit_next),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rep_q      <= '0;
      gap_q      <= '0;
      in_ready   <= 1'b0;
      dout       <= IDLE_LEVEL;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      gap_q      <= gap_d;
      in_ready   <= in_ready_d;
      dout       <= dout_d;
      dout_valid <= dout_valid_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    load    = 1'b0;
    reload  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          load    = 1'b1;
          rep_d   = in_rep;
          state_d = (len_c == '0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (!last) begin
          step = 1'b1;
        end else if (rep_q != 4'd0) begin
          rep_d = rep_q - 4'd1;
          if (GAP > 0) begin
            state_d = StGap;
            gap_d   = GW'(GAP - 1);
          end else begin
            reload = 1'b1;
          end
        end else begin
          state_d = StDone;
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StShift;
          reload  = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    dout_valid_d = (state_d == StShift);
    dout_d       = dout_valid_d ? bit_next : IDLE_LEVEL;
    busy_d       = (state_d == StShift) || (state_d == StGap);
    done_d       = (state_d == StDone);
    in_ready_d   = (state_d == StIdle);
  end

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen (W=8, GAP=2, IDLE_LEVEL=0).
module tb_seq_gen;

  logic       clk, rst_n, in_valid, in_ready;
  logic [7:0] in_data;
  logic [3:0] in_len, in_rep;
  logic       dout, dout_valid, busy, done;
  int checks = 0;
  int errors = 0;

  seq_gen #(
    .W          (8),
    .GAP        (2),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .in_rep     (in_rep),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vector: {in_ready, busy, done, dout_valid, dout}
  function automatic logic [4:0] obs();
    return {in_ready, busy, done, dout_valid, dout};
  endfunction

  task automatic start_frame(input logic [7:0] d, input logic [3:0] l, input logic [3:0] r);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_wait in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    in_rep   = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hFF;
    in_len   = 4'd7;
    in_rep   = 4'd9;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_len = '0;
    in_rep = '0;
    repeat (2) @(negedge clk);
    e = 5'b00000;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_hold got %b required %b", obs(), e);
    end
    rst_n = 1'b1;
    @(negedge clk);
    e = 5'b10000;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_release got %b required %b", obs(), e);
    end
  endtask

  task automatic test_basic();
    logic [7:0] pat = 8'b0000_0101;
    logic [4:0] e;
    start_frame(pat, 4'd3, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = {k == 5, k <= 3, k == 4, k <= 3, (k <= 3) ? pat[3-k] : 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL basic k=%0d got %b required %b", k, obs(), e);
      end
    end
  endtask

  task automatic test_repeat();
    logic [3:0] pat = 4'b0110;
    logic [4:0] e;
    int p, ndone;
    logic v;
    ndone = 0;
    start_frame({4'h0, pat}, 4'd4, 4'd2);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      p = (k - 1) % 6;
      v = (k <= 16) && (p < 4);
      e = {k == 18, k <= 16, k == 17, v, v ? pat[3-p] : 1'b0};
      if (done === 1'b1) ndone++;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL repeat k=%0d got %b required %b", k, obs(), e);
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL repeat_done_count got %0d required 1", ndone);
    end
  endtask

  task automatic test_zero_len();
    logic [4:0] e;
    start_frame(8'hFF, 4'd0, 4'd3);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e = {k >= 2, 1'b0, k == 1, 1'b0, 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL zero_len k=%0d got %b required %b", k, obs(), e);
      end
    end
  endtask

  task automatic test_clamp();
    logic [7:0] pat = 8'hA5;
    logic [4:0] e;
    start_frame(pat, 4'd12, 4'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e = {k == 10, k <= 8, k == 9, k <= 8, (k <= 8) ? pat[8-k] : 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL clamp k=%0d got %b required %b", k, obs(), e);
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] pat = 8'b0010_1101;
    logic [7:0] pat2 = 8'b0000_0110;
    logic [4:0] e;
    start_frame(pat, 4'd6, 4'd0);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      e = {1'b0, 1'b1, 1'b0, 1'b1, pat[6-k]};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_pre k=%0d got %b required %b", k, obs(), e);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    e = 5'b00000;
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL abort_reset got %b required %b", obs(), e);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      e = 5'b10000;
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_after k=%0d got %b required %b", k, obs(), e);
      end
    end
    start_frame(pat2, 4'd3, 4'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      e = {k == 5, k <= 3, k == 4, k <= 3, (k <= 3) ? pat2[3-k] : 1'b0};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL abort_new k=%0d got %b required %b", k, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a = 8'h09;
    logic [7:0] b = 8'h06;
    logic [4:0] e;
    logic va, vb;
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wait in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = a;
    in_len   = 4'd4;
    in_rep   = 4'd0;
    @(posedge clk);
    #1;
    in_data = 8'hFF;
    in_len  = 4'd8;
    in_rep  = 4'hF;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      va = (k >= 1) && (k <= 4);
      vb = (k >= 7) && (k <= 10);
      e = {k == 6 || k == 12, va || vb, k == 5 || k == 11, va || vb,
           va ? a[4-k] : (vb ? b[10-k] : 1'b0)};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL b2b k=%0d got %b required %b", k, obs(), e);
      end
      if (k == 6) begin
        in_data = b;
        in_len  = 4'd4;
        in_rep  = 4'd0;
      end else if (k <= 10) begin
        in_data = (k % 2 == 1) ? 8'h00 : 8'hFF;
        in_len  = 4'd8;
        in_rep  = 4'hF;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_zero_len();
    test_clamp();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
